// File: rtl/icache_pkg.sv
// Shared widths, FSM encoding and PC field extraction for the direct-mapped I-cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    RESP   = 2'd2
  } icache_state_t;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int xlen, input int line_words, input int num_lines);
    return xlen - 2 - off_w(line_words) - idx_w(num_lines);
  endfunction

  // Extracts pc[lsb +: width]; callers size-cast the result to the field width.
  function automatic logic [63:0] pc_field(input logic [63:0] pc, input int lsb, input int width);
    return (pc >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Line data store: synchronous write, asynchronous read, one XLEN word per address.
module icache_data_ram #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [XLEN-1:0]   o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: one-cycle hits, burst line refill on miss,
// fence.i flush that is deferred while a refill is in flight.
module icache_dm
  import icache_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req_valid,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_req_ready,
  output logic            o_instr_valid,
  output logic [XLEN-1:0] o_instruction,
  input  logic            i_flush,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_valid,
  input  logic [XLEN-1:0] i_mem_data,
  output logic            o_busy
);

  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(NUM_LINES);
  localparam int TAG_W  = tag_w(XLEN, LINE_WORDS, NUM_LINES);
  localparam int ADDR_W = IDX_W + OFF_W;

  icache_state_t state_q;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;

  logic [OFF_W-1:0] off_p1;
  logic [IDX_W-1:0] idx_p1;
  logic [TAG_W-1:0] tag_p1;

  logic [TAG_W-1:0]     tag_arr [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [OFF_W-1:0]     beat_q;
  logic                 flush_pend_q;

  logic              accept;
  logic              hit;
  logic              ram_we;
  logic              last_beat;
  logic [ADDR_W-1:0] ram_raddr;
  logic [ADDR_W-1:0] ram_waddr;
  logic [XLEN-1:0]   ram_rdata;

  assign req_off = OFF_W'(pc_field(64'(i_pc), 2, OFF_W));
  assign req_idx = IDX_W'(pc_field(64'(i_pc), OFF_W + 2, IDX_W));
  assign req_tag = TAG_W'(pc_field(64'(i_pc), OFF_W + IDX_W + 2, TAG_W));

  assign o_req_ready = (state_q == IDLE) && !i_flush;
  assign accept      = i_req_valid && o_req_ready;
  assign hit         = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);

  assign ram_we    = (state_q == REFILL) && i_mem_valid;
  assign last_beat = ram_we && (beat_q == OFF_W'(LINE_WORDS - 1));
  assign ram_waddr = {idx_p1, beat_q};
  // RESP re-reads the registered request word out of the freshly filled line.
  assign ram_raddr = (state_q == RESP) ? {idx_p1, off_p1} : {req_idx, req_off};

  icache_data_ram #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) u_data_ram (
    .i_clk   (i_clk),
    .i_we    (ram_we),
    .i_waddr (ram_waddr),
    .i_wdata (i_mem_data),
    .i_raddr (ram_raddr),
    .o_rdata (ram_rdata)
  );

  // Stage p1: registered request fields, held through the refill.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      tag_p1 <= req_tag;
      idx_p1 <= req_idx;
      off_p1 <= req_off;
    end
  end

  always_ff @(posedge i_clk) begin
    if (last_beat) tag_arr[idx_p1] <= tag_p1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      beat_q        <= '0;
      flush_pend_q  <= 1'b0;
      o_instr_valid <= 1'b0;
      o_instruction <= '0;
      o_mem_req     <= 1'b0;
      o_mem_addr    <= '0;
      o_busy        <= 1'b0;
    end else begin
      o_instr_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_flush) begin
            valid_q <= '0;
          end else if (accept) begin
            if (hit) begin
              o_instr_valid <= 1'b1;
              o_instruction <= ram_rdata;
            end else begin
              state_q      <= REFILL;
              o_mem_req    <= 1'b1;
              o_mem_addr   <= {req_tag, req_idx, {(OFF_W + 2){1'b0}}};
              o_busy       <= 1'b1;
              beat_q       <= '0;
              flush_pend_q <= 1'b0;
            end
          end
        end
        REFILL: begin
          if (i_flush) flush_pend_q <= 1'b1;
          if (ram_we) begin
            beat_q <= beat_q + OFF_W'(1);
            if (last_beat) begin
              if (!(flush_pend_q || i_flush)) valid_q[idx_p1] <= 1'b1;
              o_mem_req <= 1'b0;
              state_q   <= RESP;
            end
          end
        end
        RESP: begin
          o_instr_valid <= 1'b1;
          o_instruction <= ram_rdata;
          o_busy        <= 1'b0;
          state_q       <= IDLE;
          // A flush seen during the refill takes effect only once the response is out.
          if (flush_pend_q || i_flush) valid_q <= '0;
          flush_pend_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, hits, conflict, flushes, gapped beats, mid-refill reset.
module tb_icache_dm;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_req_valid;
  logic [31:0] i_pc;
  logic        o_req_ready;
  logic        o_instr_valid;
  logic [31:0] o_instruction;
  logic        i_flush;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_valid;
  logic [31:0] i_mem_data;
  logic        o_busy;

  int vectors     = 0;
  int miscompares = 0;

  icache_dm #(
    .XLEN       (32),
    .LINE_WORDS (4),
    .NUM_LINES  (64)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req_valid   (i_req_valid),
    .i_pc          (i_pc),
    .o_req_ready   (o_req_ready),
    .o_instr_valid (o_instr_valid),
    .o_instruction (o_instruction),
    .i_flush       (i_flush),
    .o_mem_req     (o_mem_req),
    .o_mem_addr    (o_mem_addr),
    .i_mem_valid   (i_mem_valid),
    .i_mem_data    (i_mem_data),
    .o_busy        (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue_miss(input logic [31:0] pc);
    i_req_valid = 1'b1;
    i_pc        = pc;
    #1;
    chk("miss_ready", o_req_ready, 1);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    chk("miss_mem_req", o_mem_req, 1);
    chk("miss_mem_addr", o_mem_addr, pc & 32'hFFFF_FFF0);
    chk("miss_busy", o_busy, 1);
    chk("miss_no_resp", o_instr_valid, 0);
  endtask

  task automatic issue_hit(input logic [31:0] pc, input logic [31:0] exp);
    i_req_valid = 1'b1;
    i_pc        = pc;
    @(negedge i_clk);
    chk("hit_valid", o_instr_valid, 1);
    chk("hit_instr", o_instruction, exp);
    chk("hit_no_mem_req", o_mem_req, 0);
  endtask

  // Feeds four beats d0..d0+3; optional idle gaps and a flush pulse after one beat.
  task automatic refill(input logic [31:0] d0, input int gap, input int flush_after,
                        input logic [31:0] exp);
    for (int i = 0; i < 4; i++) begin
      i_mem_valid = 1'b1;
      i_mem_data  = d0 + i;
      @(negedge i_clk);
      i_mem_valid = 1'b0;
      i_mem_data  = 32'hDEAD_BEEF;
      if (i < 3) begin
        chk("refill_mem_req_held", o_mem_req, 1);
        if (i == flush_after) begin
          i_flush = 1'b1;
          @(negedge i_clk);
          i_flush = 1'b0;
        end
        for (int g = 0; g < gap; g++) @(negedge i_clk);
      end
    end
    chk("refill_mem_req_drop", o_mem_req, 0);
    chk("refill_resp_not_yet", o_instr_valid, 0);
    chk("refill_busy_resp", o_busy, 1);
    @(negedge i_clk);
    chk("refill_resp_valid", o_instr_valid, 1);
    chk("refill_resp_instr", o_instruction, exp);
    chk("refill_idle_busy", o_busy, 0);
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_req_valid = 1'b0;
    i_pc        = '0;
    i_flush     = 1'b0;
    i_mem_valid = 1'b0;
    i_mem_data  = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_ready", o_req_ready, 1);
    chk("rst_instr_valid", o_instr_valid, 0);
    chk("rst_instruction", o_instruction, 0);
    chk("rst_mem_req", o_mem_req, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_busy", o_busy, 0);

    // Cold miss
    issue_miss(32'h0000_0010);
    refill(32'h0000_00A0, 0, -1, 32'h0000_00A0);

    // Beats outside REFILL are ignored
    i_mem_valid = 1'b1;
    i_mem_data  = 32'h0000_0055;
    @(negedge i_clk);
    i_mem_valid = 1'b0;
    chk("idle_beat_no_resp", o_instr_valid, 0);
    chk("idle_beat_no_req", o_mem_req, 0);

    // Back-to-back hits
    issue_hit(32'h0000_0014, 32'h0000_00A1);
    issue_hit(32'h0000_0018, 32'h0000_00A2);
    issue_hit(32'h0000_001C, 32'h0000_00A3);
    issue_hit(32'h0000_0010, 32'h0000_00A0);
    i_req_valid = 1'b0;
    @(negedge i_clk);
    chk("pulse_drop", o_instr_valid, 0);
    chk("instr_hold", o_instruction, 32'h0000_00A0);

    // Conflict eviction, then gapped refill of the evicted line
    issue_miss(32'h0000_0410);
    refill(32'h0000_00B0, 0, -1, 32'h0000_00B0);
    issue_hit(32'h0000_041C, 32'h0000_00B3);
    issue_miss(32'h0000_0010);
    refill(32'h0000_00C0, 2, -1, 32'h0000_00C0);
    issue_hit(32'h0000_0018, 32'h0000_00C2);
    i_req_valid = 1'b0;
    @(negedge i_clk);

    // Flush in IDLE blocks the same-cycle request
    i_flush     = 1'b1;
    i_req_valid = 1'b1;
    i_pc        = 32'h0000_0010;
    #1;
    chk("flush_ready_low", o_req_ready, 0);
    @(negedge i_clk);
    i_flush = 1'b0;
    chk("flush_not_accepted", o_instr_valid, 0);
    chk("flush_no_mem_req", o_mem_req, 0);
    issue_miss(32'h0000_0010);
    refill(32'h0000_00D0, 0, -1, 32'h0000_00D0);

    // Flush during refill: word still delivered, line left invalid
    issue_miss(32'h0000_0024);
    refill(32'h0000_00E0, 0, 1, 32'h0000_00E1);
    issue_miss(32'h0000_0024);
    refill(32'h0000_00F0, 0, -1, 32'h0000_00F1);

    // Reset mid-refill
    issue_miss(32'h0000_0010);
    for (int i = 0; i < 3; i++) begin
      i_mem_valid = 1'b1;
      i_mem_data  = 32'h0000_0070 + i;
      @(negedge i_clk);
    end
    i_mem_valid = 1'b0;
    i_rst_n     = 1'b0;
    #1;
    chk("midrst_mem_req", o_mem_req, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_no_resp", o_instr_valid, 0);
    chk("midrst_mem_addr", o_mem_addr, 0);
    @(negedge i_clk);
    chk("midrst_hold_no_resp", o_instr_valid, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("midrst_after_no_resp", o_instr_valid, 0);
    chk("midrst_after_ready", o_req_ready, 1);
    issue_miss(32'h0000_0024);
    refill(32'h0000_0090, 0, -1, 32'h0000_0091);
    issue_hit(32'h0000_002C, 32'h0000_0093);
    i_req_valid = 1'b0;
    @(negedge i_clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
